// File: rtl/deconv_kernel_phase_debug_readout.sv
// Debug dump of the phase SRAM: reads DEPTH words and serializes them MSB first.
// Optional macro DECONV_READOUT_PARITY_EN appends an even-parity bit to every word.
module deconv_kernel_phase_debug_readout #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2048,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  debug,
    input  logic                  readout_start,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  debug_read_trig,
    input  logic                  ser_ready,
    output logic                  ser_data,
    output logic                  ser_valid,
    output logic                  ser_word_last,
    output logic                  busy,
    output logic                  done
);

`ifdef DECONV_READOUT_PARITY_EN
    localparam int WORD_BITS = DATA_WIDTH + 1;
`else
    localparam int WORD_BITS = DATA_WIDTH;
`endif
    localparam int                   BIT_W     = $clog2(WORD_BITS);
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, PRIME, LOAD, SHIFT, FINISH} state_e;

    state_e               state_q;
    logic [WORD_BITS-1:0] shreg_q;
    logic [BIT_W-1:0]     bit_q;
    logic [CNT_WIDTH-1:0] word_q;
    logic                 trig_q, valid_q, last_q, busy_q, done_q;
    logic [WORD_BITS-1:0] load_word;

`ifdef DECONV_READOUT_PARITY_EN
    assign load_word = {rdata, ^rdata};
`else
    assign load_word = rdata;
`endif

    // ser_data is the shift-register MSB; the register is kept zero outside SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            if (state_q != IDLE && !debug) begin
                state_q <= IDLE;
                shreg_q <= '0;
                bit_q   <= '0;
                word_q  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (readout_start && debug) begin
                            state_q <= PRIME;
                            busy_q  <= 1'b1;
                            word_q  <= '0;
                            bit_q   <= '0;
                            shreg_q <= '0;
                        end
                    end
                    PRIME: begin
                        state_q <= LOAD;
                        trig_q  <= 1'b1;
                    end
                    LOAD: begin
                        state_q <= SHIFT;
                        shreg_q <= load_word;
                        bit_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                    SHIFT: begin
                        if (ser_ready) begin
                            if (bit_q == LAST_BIT) begin
                                shreg_q <= '0;
                                bit_q   <= '0;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                if (word_q == LAST_WORD) begin
                                    state_q <= FINISH;
                                    done_q  <= 1'b1;
                                end else begin
                                    // Next word's read was issued by the previous trig pulse.
                                    word_q  <= word_q + CNT_WIDTH'(1);
                                    state_q <= LOAD;
                                    trig_q  <= 1'b1;
                                end
                            end else begin
                                shreg_q <= {shreg_q[WORD_BITS-2:0], 1'b0};
                                last_q  <= ((bit_q + BIT_W'(1)) == LAST_BIT);
                                bit_q   <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        word_q  <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign debug_read_trig = trig_q;
    assign ser_data        = shreg_q[WORD_BITS-1];
    assign ser_valid       = valid_q;
    assign ser_word_last   = last_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_deconv_kernel_phase_debug_readout.sv
// Bench for deconv_kernel_phase_debug_readout: SRAM model plus a bit-queue reference of the dump.
module tb_deconv_kernel_phase_debug_readout;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef DECONV_READOUT_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          debug = 1'b0;
    logic          readout_start = 1'b0;
    logic          ser_ready = 1'b0;
    logic [DW-1:0] rdata;
    logic          debug_read_trig, ser_data, ser_valid, ser_word_last, busy, done;

    logic [DW-1:0] mem [DEPTH];
    int            addr;
    bit            expq [$];
    int            checks = 0;
    int            failures = 0;

    deconv_kernel_phase_debug_readout #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .debug(debug), .readout_start(readout_start),
        .rdata(rdata), .debug_read_trig(debug_read_trig), .ser_ready(ser_ready),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_word_last(ser_word_last),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    // Phase SRAM: registered read, address advanced by trig, reset while debug is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= 0;
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
            if (!debug) addr <= 0;
            else if (debug_read_trig) addr <= (addr + 1) % DEPTH;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        expq.delete();
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = DW - 1; b >= 0; b--) expq.push_back(mem[w][b]);
`ifdef DECONV_READOUT_PARITY_EN
            expq.push_back(^mem[w]);
`endif
        end
    endtask

    // mode 0: ready always 1; mode 1: every bit stalled once then accepted; mode 2: random.
    task automatic run_dump(input int mode, input int abort_idx, input int restart_at);
        int idx, cyc, trig, shc;
        bit fin, held, ph, aborted;
        logic hd, hl;
        idx = 0; cyc = 0; trig = 0; shc = 0;
        fin = 0; held = 0; aborted = 0; hd = 0; hl = 0;
        build_exp();
        @(negedge clk); debug = 1'b1; readout_start = 1'b1; ser_ready = 1'b0;
        @(negedge clk); readout_start = 1'b0;
        chk("busy_prime", busy, 1);
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (debug_read_trig) trig++;
            ph = held;
            if (held) begin
                chk("hold_valid", ser_valid, 1);
                chk("hold_data", ser_data, hd);
                chk("hold_last", ser_word_last, hl);
            end
            held = 0;
            if (aborted) begin
                chk("abort_outputs", {busy, ser_valid, ser_data, ser_word_last, debug_read_trig, done}, 0);
                fin = 1;
            end else if (ser_valid) begin
                shc++;
                if (idx < expq.size()) chk("bit", ser_data, expq[idx]);
                else chk("extra_bit", idx, expq.size() - 1);
                chk("word_last", ser_word_last, (idx % WW) == WW - 1);
                if (abort_idx >= 0 && idx == abort_idx) begin
                    debug = 1'b0;
                    aborted = 1;
                end else begin
                    ser_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
                    if (ser_ready) idx++;
                    else begin
                        held = 1; hd = ser_data; hl = ser_word_last;
                    end
                end
            end else begin
                chk("idle_data", {ser_data, ser_word_last}, 0);
                ser_ready = 1'($urandom_range(0, 1));
            end
            if (!aborted && done) begin
                chk("done_after_last", idx, expq.size());
                fin = 1;
            end
            readout_start = (restart_at >= 0 && idx == restart_at);
        end
        readout_start = 1'b0;
        chk("finished", fin, 1);
        if (aborted) begin
            repeat (5) begin
                @(negedge clk);
                chk("abort_no_done", {busy, done, ser_valid}, 0);
            end
        end else begin
            chk("trig_count", trig, DEPTH);
            if (mode == 0) chk("shift_cycles", shc, DEPTH * WW);
            if (mode == 1) chk("shift_cycles_stall", shc, 2 * DEPTH * WW);
            @(negedge clk);
            chk("post_done", {busy, done}, 0);
        end
    endtask

    initial begin
        mem[0] = 16'hA5A5; mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
        #1 rst_n = 1'b0;
        #1 chk("reset_outputs", {busy, ser_valid, ser_data, ser_word_last, debug_read_trig, done}, 0);
        @(negedge clk); rst_n = 1'b1;

        // start ignored without debug
        @(negedge clk); debug = 1'b0; readout_start = 1'b1;
        @(negedge clk); readout_start = 1'b0;
        repeat (4) begin
            chk("nodebug_idle", {busy, debug_read_trig}, 0);
            @(negedge clk);
        end

        run_dump(0, -1, -1);
        run_dump(1, -1, -1);
        run_dump(0, -1, 10);
        run_dump(0, 2 * WW + 5, -1);
        run_dump(0, -1, -1);

        // asynchronous reset in the middle of SHIFT
        @(negedge clk); debug = 1'b1; readout_start = 1'b1; ser_ready = 1'b1;
        @(negedge clk); readout_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_shift_valid", ser_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {busy, ser_valid, ser_data, ser_word_last, debug_read_trig, done}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_idle", {busy, ser_valid, debug_read_trig}, 0);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            run_dump(2, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/deconv_kernel_phase_debug_readout.md
DECONV_KERNEL_PHASE_DEBUG_READOUT -- requirements
Module: deconv_kernel_phase_debug_readout

Interface
REQ-001 Parameter DATA_WIDTH, default 16: SRAM word width; legal values are 2 or greater.
REQ-002 Parameter DEPTH, default 2048: number of words read per dump.
REQ-003 Parameter CNT_WIDTH, default 12: word-counter width, equal to ceil(log2(DEPTH))+1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 debug  input  1  debug mode enable; also drives the phase SRAM interface's debug input.
REQ-007 readout_start  input  1  single-cycle request to begin a dump.
REQ-008 rdata  input  DATA_WIDTH  phase SRAM read data; valid one cycle after address presented.
REQ-009 debug_read_trig  output  1  single-cycle pulse advancing the SRAM read address.
REQ-010 ser_ready  input  1  downstream accepts ser_data this cycle.
REQ-011 ser_data  output  1  serial bit, MSB first.
REQ-012 ser_valid  output  1  ser_data valid.
REQ-013 ser_word_last  output  1  high with the final bit of each word.
REQ-014 busy  output  1  dump in progress.
REQ-015 done  output  1  single-cycle pulse after the last bit of word DEPTH-1 is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, PRIME, LOAD, SHIFT and FINISH.
REQ-017 IDLE -> PRIME SHALL occur when readout_start=1 and debug=1; readout_start with debug=0 SHALL be ignored.
REQ-018 PRIME SHALL last exactly one cycle, allowing rdata for address 0 to settle, then go to LOAD.
REQ-019 LOAD SHALL last one cycle: capture rdata into the shift register, pulse debug_read_trig=1, go to SHIFT.
REQ-020 In SHIFT, ser_valid=1 and ser_data=current MSB; a bit SHALL advance only on cycles with ser_valid=1 and ser_ready=1.
REQ-021 ser_data, ser_valid and ser_word_last SHALL hold stable while ser_ready=0.
REQ-022 On acceptance of the last bit of a word: if word count = DEPTH-1, go to FINISH, else increment the count and go to LOAD.
REQ-023 FINISH SHALL last one cycle, pulse done=1, then return to IDLE.
REQ-024 debug_read_trig SHALL pulse exactly DEPTH times per complete dump; its pulse after the last word SHALL be harmless, as the address wraps.
REQ-025 busy SHALL be 1 in PRIME, LOAD, SHIFT and FINISH, and 0 in IDLE.
REQ-026 readout_start while busy=1 SHALL be ignored.
REQ-027 debug falling to 0 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, clear counters and deassert all outputs, with no done pulse.
REQ-028 Outside SHIFT, ser_valid=0, ser_data=0 and ser_word_last=0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, zero all counters and the shift register, and drive every output to 0.
REQ-030 Reset deassertion mid-dump SHALL NOT resume the dump; a new readout_start is required.

Configuration
REQ-031 Macro DECONV_READOUT_PARITY_EN defined: each word SHALL be followed by one even-parity bit (XOR of the DATA_WIDTH data bits), so the word is DATA_WIDTH+1 bits and ser_word_last marks the parity bit.
REQ-032 Macro DECONV_READOUT_PARITY_EN undefined: each word SHALL be DATA_WIDTH bits and ser_word_last marks bit 0.

Verification
REQ-033 DEPTH=4, DATA_WIDTH=16, SRAM preloaded 0xA5A5, 0x0001, 0x8000, 0xFFFF, ser_ready tied 1 -> 64 bits serialized in that order MSB first, 4 trig pulses, done 1 cycle after the last bit.
REQ-034 Same setup, ser_ready toggling 1,0,1,0 -> identical bit sequence, outputs held stable on stalled cycles, dump takes 128 SHIFT cycles.
REQ-035 readout_start with debug=0 -> busy stays 0 and no trig pulse; a second readout_start during a dump -> no effect.
REQ-036 debug dropped during word 2 bit 5 -> IDLE next cycle, all outputs 0, no done; a new dump restarts from word 0 (0xA5A5).
REQ-037 rst_n asserted mid-SHIFT -> outputs 0 immediately, without waiting for a clock edge; after release, busy=0 until a new readout_start.
REQ-038 With DECONV_READOUT_PARITY_EN, word 0x0001 -> 17 bits ending in parity 1, and 0xA5A5 -> parity 0.
